// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*WIDTH working register, fixed 34-cycle latency for every funct3.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [DW-1:0]    acc_q;
  logic [WIDTH-1:0] b_mag_q;
  logic [WIDTH-1:0] dividend_q;
  logic             a_neg_q;
  logic             b_neg_q;
  logic             div0_q;
  logic             ovf_q;
  logic [4:0]       rd_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       result_rd_q;

  logic             signed_a_s;
  logic             signed_b_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic             div0_s;
  logic             ovf_s;
  logic [DW-1:0]    acc_d;
  logic [WIDTH-1:0] result_d;

  // Operand signedness decoded from the incoming funct3 at acceptance.
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (funct3)
      F_MUL, F_MULH, F_DIV, F_REM: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b1;
      end
      F_MULHSU: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b0;
      end
      default: begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
      end
    endcase
  end

  assign a_neg_s = signed_a_s & rs1_data[WIDTH-1];
  assign b_neg_s = signed_b_s & rs2_data[WIDTH-1];
  assign a_mag_s = a_neg_s ? (~rs1_data + {{(WIDTH-1){1'b0}}, 1'b1}) : rs1_data;
  assign b_mag_s = b_neg_s ? (~rs2_data + {{(WIDTH-1){1'b0}}, 1'b1}) : rs2_data;
  assign div0_s  = (rs2_data == ZERO_W);
  assign ovf_s   = funct3[2] & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == ALL_ONES);

  logic [WIDTH:0]   mul_sum_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_rem_s;

  // One iteration step: multiply adds the multiplicand into the top half and shifts
  // right; divide shifts left and keeps the trial difference when it does not go negative.
  always_comb begin
    mul_sum_s = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : {(WIDTH+1){1'b0}});
    div_ge_s  = (acc_q[DW-1:WIDTH-1] >= {1'b0, b_mag_q});
    div_rem_s = acc_q[DW-2:WIDTH-1] - b_mag_q;
    if (op_q[2]) begin
      if (div_ge_s) begin
        acc_d = {div_rem_s, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[DW-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  logic [DW-1:0]    prod_s;
  logic [WIDTH-1:0] quot_s;
  logic [WIDTH-1:0] rem_s;

  // Sign correction, word selection and RISC-V special cases applied in FIXUP.
  always_comb begin
    prod_s   = (a_neg_q ^ b_neg_q) ? (~acc_q + {{(DW-1){1'b0}}, 1'b1}) : acc_q;
    quot_s   = (a_neg_q ^ b_neg_q) ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                                   : acc_q[WIDTH-1:0];
    rem_s    = a_neg_q ? (~acc_q[DW-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q[DW-1:WIDTH];
    result_d = ZERO_W;
    case (op_q)
      F_MUL:                       result_d = prod_s[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU:   result_d = prod_s[DW-1:WIDTH];
      F_DIV, F_DIVU: begin
        if (div0_q) begin
          result_d = ALL_ONES;
        end else if (ovf_q) begin
          result_d = MIN_NEG;
        end else begin
          result_d = quot_s;
        end
      end
      F_REM, F_REMU: begin
        if (div0_q) begin
          result_d = dividend_q;
        end else if (ovf_q) begin
          result_d = ZERO_W;
        end else begin
          result_d = rem_s;
        end
      end
      default:                     result_d = ZERO_W;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      op_q        <= 3'b000;
      acc_q       <= {DW{1'b0}};
      b_mag_q     <= ZERO_W;
      dividend_q  <= ZERO_W;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rd_q        <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= ZERO_W;
      result_rd_q <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_CALC;
            cnt_q      <= {CW{1'b0}};
            op_q       <= funct3;
            acc_q      <= {ZERO_W, a_mag_s};
            b_mag_q    <= b_mag_s;
            dividend_q <= rs1_data;
            a_neg_q    <= a_neg_s;
            b_neg_q    <= b_neg_s;
            div0_q     <= div0_s;
            ovf_q      <= ovf_s;
            rd_q       <= rd;
            busy_q     <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIXUP;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_FIXUP: begin
          result_q    <= result_d;
          result_rd_q <= rd_q;
          done_q      <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_rd = result_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special cases,
// start-ignore while busy, and reset mid-operation.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_rd (result_rd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE, scramble inputs after acceptance, then check timing and result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
    int lat;
    int nbusy;
    logic seen;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd = r;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = ~f3; rs1_data = ~a; rs2_data = b ^ 32'h5A5A_A5A5; rd = ~r;
    lat = 0; nbusy = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    check_eq({tag, " latency"}, lat, 32'd34);
    check_eq({tag, " busy_cycles"}, nbusy, 32'd34);
    check_eq({tag, " result"}, result, exp);
    check_eq({tag, " result_rd"}, {27'd0, result_rd}, {27'd0, r});
    @(negedge clk);
    check_eq({tag, " done_pulse_end"}, {31'd0, done}, 32'd0);
    check_eq({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int npulse;
    logic seen;

    reset = 1'b0; start = 1'b0; funct3 = 3'b000;
    rs1_data = 32'd0; rs2_data = 32'd0; rd = 5'd0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    check_eq("reset result", result, 32'd0);
    check_eq("reset result_rd", {27'd0, result_rd}, 32'd0);
    reset = 1'b1;

    run_op("MUL",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op("MULH",     3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
    run_op("MULHU",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
    run_op("MULHSU",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
    run_op("DIV",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD);
    run_op("REM",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF);
    run_op("DIVU",     3'b101, 32'd100,       32'd7,         5'd11, 32'h0000_000E);
    run_op("REMU",     3'b111, 32'd100,       32'd7,         5'd12, 32'h0000_0002);
    run_op("DIVU big", 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13, 32'h0000_0001);
    run_op("REMU big", 3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd14, 32'h7FFF_FFFE);
    run_op("DIV by0",  3'b100, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF);
    run_op("REMU by0", 3'b111, 32'd5,         32'd0,         5'd16, 32'h0000_0005);
    run_op("DIV neg0", 3'b100, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFFF);
    run_op("REM neg0", 3'b110, 32'hFFFF_FFF9, 32'd0,         5'd19, 32'hFFFF_FFF9);
    run_op("DIV ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000);
    run_op("REM ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h0000_0000);

    // start held high: second op must wait for the first IDLE cycle after DONE
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'h0000_0007; rs2_data = 32'hFFFF_FFFD; rd = 5'd5;
    @(posedge clk);
    #1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
      end else begin
        funct3 = 3'b101; rs1_data = $urandom; rs2_data = $urandom; rd = 5'd17;
      end
    end
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd17;
    check_eq("b2b op1 latency", lat, 32'd34);
    check_eq("b2b op1 result", result, 32'hFFFF_FFEB);
    check_eq("b2b op1 result_rd", {27'd0, result_rd}, 32'd5);
    @(negedge clk);
    check_eq("b2b idle busy", {31'd0, busy}, 32'd0);
    check_eq("b2b result held", result, 32'hFFFF_FFEB);
    lat = 1; seen = 1'b0;
    while (!seen && lat < 80) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check_eq("b2b op2 spacing", lat, 32'd35);
    check_eq("b2b op2 result", result, 32'h0000_000E);
    check_eq("b2b op2 result_rd", {27'd0, result_rd}, 32'd17);
    @(negedge clk);

    // reset in the middle of a DIVU discards it entirely
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst busy", {31'd0, busy}, 32'd0);
    check_eq("midrst done", {31'd0, done}, 32'd0);
    check_eq("midrst result", result, 32'd0);
    check_eq("midrst result_rd", {27'd0, result_rd}, 32'd0);
    reset = 1'b1;
    npulse = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check_eq("midrst no done", npulse, 32'd0);

    run_op("MUL after rst", 3'b000, 32'd3, 32'd4, 5'd3, 32'h0000_000C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file: it consumes read_data1/read_data2 as operands and produces a result plus destination index for the register-file write port (write_reg/write_data).
- It uses a fixed-latency shift-add multiplier and a restoring divider sharing one 64-bit working register, and handles all eight M-extension funct3 encodings.
- The core stalls on busy and writes back on done.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- ITER, 32, number of CALC iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request; accepted only when state is IDLE.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  WIDTH  operand A / dividend (register file read_data1).
- rs2_data  input  WIDTH  operand B / divisor (register file read_data2).
- rd  input  5  destination register index.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- done  output  1  single-cycle pulse; result and result_rd are valid.
- result  output  WIDTH  result; held until the next accepted start.
- result_rd  output  5  captured rd; held with result.

Behaviour:
- Reset (reset==0 at an edge):
  - state goes to IDLE.
  - busy=0, done=0, result=0, result_rd=0, iteration counter=0.
  - Reset has priority over every other event, including mid-operation: the in-flight op is discarded and done never pulses for it.
- State machine:
  - IDLE -> CALC on an edge with start=1. That edge, E0, captures funct3, operands, rd, operand signs, and special-case flags. Operand start/busy are ignored while not IDLE; no queuing.
  - CALC: 32 cycles, counter 0..31. Multiply: add-and-shift on the magnitude of the operands. Divide: restoring step on magnitudes (shift remainder left, trial subtract, set quotient bit).
  - CALC -> FIXUP when counter==31.
  - FIXUP: 1 cycle. Applies sign correction, selects the high/low word, applies special cases, and loads result.
  - FIXUP -> DONE unconditionally.
  - DONE: done=1 for exactly 1 cycle, then -> IDLE. A start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
- Latency: fixed. done is high in the cycle following edge E0+33 (34 cycles after acceptance), for every op including special cases.
- busy: 1 in cycles after edges E0..E0+33; 0 in IDLE.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: unsigned.
- Multiply result selection:
  - MUL returns the low 32 bits of the 64-bit product.
  - MULH/MULHSU/MULHU return the high 32 bits.
  - Negative product = two's complement of the full 64-bit magnitude product.
- Division rounding: truncates toward zero; remainder takes the sign of the dividend.
- Special cases (RISC-V defined, no trap):
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - Overflow, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Operand inputs may change freely after E0; only the captured values are used.
- result/result_rd change only in the FIXUP->DONE transition or on reset.

Test Plan:
- MUL 0x00000007 x 0xFFFFFFFD, rd=5 -> done pulse exactly 34 cycles after acceptance, result=0xFFFFFFEB, result_rd=5, busy=1 for 34 cycles.
- High products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 0x0000000E; REMU 100 / 7 -> 0x00000002.
- Special cases:
  - DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
  - All with 34-cycle latency.
- Back-to-back / ignore:
  - start=1 held continuously with changing operands during an op -> the second op is accepted only in the first IDLE cycle after DONE.
  - Results of op 1 are unaffected by mid-op operand changes.
- Reset mid-op: reset=0 at cycle 10 of a DIVU -> next cycle busy=0, result=0, result_rd=0, no done pulse. A subsequent MUL 3 x 4 -> 0x0000000C.
